// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single 8N1 UART transmitter.
// A byte is accepted only while the transmitter is idle and is sent LSB first.
module uart_tx_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       io_mainClk,
  input  logic       io_asyncReset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       io_uart_txd,
  output logic       busy,
  output logic       grant_id
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic          idle;
  logic          winner;
  logic          bit_end;

  // Under contention the requester that was not served last wins.
  always_comb begin
    if (req0_valid && req1_valid) winner = ~last_q;
    else                          winner = req1_valid;
  end

  assign idle        = (state_q == IDLE);
  assign busy        = ~idle;
  assign req0_ready  = idle && !io_asyncReset && req0_valid && !winner;
  assign req1_ready  = idle && !io_asyncReset && req1_valid && winner;
  assign bit_end     = (timer_q == TIMER_LAST);
  assign io_uart_txd = txd_q;
  assign grant_id    = grant_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    grant_d   = grant_q;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        timer_d   = '0;
        bit_idx_d = '0;
        txd_d     = 1'b1;
        if (req0_ready || req1_ready) begin
          shift_d = winner ? req1_data : req0_data;
          grant_d = winner;
          last_d  = winner;
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        timer_d = bit_end ? '0 : timer_q + TW'(1);
        if (bit_end) begin
          txd_d   = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        timer_d = bit_end ? '0 : timer_q + TW'(1);
        if (bit_end) begin
          shift_d = shift_q >> 1;
          // txd is registered, so the next bit is taken from shift_q[1] one cycle early.
          if (bit_idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end
      end
      STOP: begin
        timer_d = bit_end ? '0 : timer_q + TW'(1);
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a frame-position reference model is
// compared every cycle, plus directed scenarios pinned with literal expectations.
module tb_uart_tx_arbiter;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst;
  logic       v0, v1;
  logic [7:0] d0, d1;
  logic       r0, r1;
  logic       txd, busy, gid;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bit acc0, acc1, keep0, keep1;

  int         log_cyc[$];
  bit         log_id[$];
  logic [7:0] log_data[$];

  // Reference model: whether a frame is running, position inside it, and its byte.
  bit         m_active;
  int         m_pos;
  logic [7:0] m_byte;
  bit         m_grant;
  bit         m_last;

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB)) dut (
    .io_mainClk    (clk),
    .io_asyncReset (rst),
    .req0_valid    (v0),
    .req0_data     (d0),
    .req0_ready    (r0),
    .req1_valid    (v1),
    .req1_data     (d1),
    .req1_ready    (r1),
    .io_uart_txd   (txd),
    .busy          (busy),
    .grant_id      (gid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: sample after the inputs settle, then advance the model on the edge.
  always begin : compare_proc
    bit exp_r0, exp_r1, exp_txd, win;
    int bitno;
    @(negedge clk);
    #2;
    if (rst) begin
      m_active = 1'b0;
      m_pos    = 0;
      m_byte   = 8'h00;
      m_grant  = 1'b0;
      m_last   = 1'b1;
      check_output("reset_txd", txd, 1);
      check_output("reset_busy", busy, 0);
      check_output("reset_grant", gid, 0);
    end else begin
      win    = (v0 && v1) ? !m_last : v1;
      exp_r0 = !m_active && v0 && !win;
      exp_r1 = !m_active && v1 && win;
      if (m_active) begin
        bitno = m_pos / CPB;
        if (bitno == 0)      exp_txd = 1'b0;
        else if (bitno == 9) exp_txd = 1'b1;
        else                 exp_txd = m_byte[bitno-1];
      end else begin
        exp_txd = 1'b1;
      end
      check_output("ready0", r0, exp_r0);
      check_output("ready1", r1, exp_r1);
      check_output("txd", txd, exp_txd);
      check_output("busy", busy, m_active);
      check_output("grant_id", gid, m_grant);
      if (r0 && v0) begin
        log_cyc.push_back(cyc); log_id.push_back(1'b0); log_data.push_back(d0); acc0 = 1'b1;
      end
      if (r1 && v1) begin
        log_cyc.push_back(cyc); log_id.push_back(1'b1); log_data.push_back(d1); acc1 = 1'b1;
      end
      @(posedge clk);
      if (!rst) begin
        if (m_active) begin
          m_pos++;
          if (m_pos == FRAME) m_active = 1'b0;
        end else if (exp_r0 || exp_r1) begin
          m_active = 1'b1;
          m_pos    = 0;
          m_byte   = win ? d1 : d0;
          m_grant  = win;
          m_last   = win;
        end
      end
    end
  end

  task automatic apply_stimulus();
    @(negedge clk);
    if (acc0) begin
      acc0 = 1'b0;
      if (keep0) d0 = d0 + 8'd1; else v0 = 1'b0;
    end
    if (acc1) begin
      acc1 = 1'b0;
      if (keep1) d1 = d1 + 8'd1; else v1 = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
    acc0 = 1'b0; acc1 = 1'b0; keep0 = 1'b0; keep1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    log_cyc.delete(); log_id.delete(); log_data.delete();
  endtask

  task automatic wait_xfers(input int n, input int budget, input string name);
    int k = 0;
    while (log_cyc.size() < n && k < budget) begin
      apply_stimulus();
      k++;
    end
    checks++;
    if (log_cyc.size() < n) begin
      failures++;
      $display("[TB] FAIL %s: got %0d transfers, expected %0d within %0d cycles", name, log_cyc.size(), n, budget);
    end
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) apply_stimulus();
  endtask

  initial begin
    logic [9:0] exp_seq;
    logic       samp[FRAME];
    int         rel_cyc;

    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
    acc0 = 1'b0; acc1 = 1'b0; keep0 = 1'b0; keep1 = 1'b0;

    // Single byte 0xA5: start, LSB first, stop, 4 cycles per bit.
    do_reset();
    v0 = 1'b1; d0 = 8'hA5;
    wait_xfers(1, 5, "single_accept");
    for (int k = 0; k < FRAME; k++) begin
      #3;
      samp[k] = txd;
      check_output("single_busy", busy, 1);
      apply_stimulus();
    end
    #3;
    check_output("single_idle_after", busy, 0);
    exp_seq = 10'b1101001010;
    for (int b = 0; b < 10; b++) check_output("single_bit", samp[4*b+1], exp_seq[b]);
    check_output("single_one_xfer", log_cyc.size(), 1);

    // Contention after reset: requester 0 first, second start 41 cycles later.
    do_reset();
    v0 = 1'b1; d0 = 8'h11; v1 = 1'b1; d1 = 8'h22;
    wait_xfers(2, 100, "contend_xfers");
    check_output("contend_first_id", log_id[0], 0);
    check_output("contend_first_data", log_data[0], 8'h11);
    check_output("contend_second_id", log_id[1], 1);
    check_output("contend_second_data", log_data[1], 8'h22);
    check_output("contend_spacing", log_cyc[1] - log_cyc[0], 41);
    drain(45);

    // Fairness: both streaming for four frames.
    do_reset();
    keep0 = 1'b1; keep1 = 1'b1;
    v0 = 1'b1; d0 = 8'h30; v1 = 1'b1; d1 = 8'h40;
    wait_xfers(4, 250, "fair_xfers");
    v0 = 1'b0; v1 = 1'b0; keep0 = 1'b0; keep1 = 1'b0;
    for (int k = 0; k < 4; k++) check_output("fair_grant", log_id[k], k % 2);
    for (int k = 1; k < 4; k++) check_output("fair_spacing", log_cyc[k] - log_cyc[k-1], 41);
    drain(45);

    // Single requester streaming on req1.
    do_reset();
    keep1 = 1'b1; v1 = 1'b1; d1 = 8'h5A;
    wait_xfers(3, 200, "stream_xfers");
    v1 = 1'b0; keep1 = 1'b0;
    for (int k = 0; k < 3; k++) check_output("stream_grant", log_id[k], 1);
    for (int k = 1; k < 3; k++) check_output("stream_spacing", log_cyc[k] - log_cyc[k-1], 41);
    drain(45);

    // Reset in the middle of data bit 3, then a pending req0 is served at once.
    do_reset();
    v0 = 1'b1; d0 = 8'hF0;
    wait_xfers(1, 5, "midreset_accept");
    for (int k = 0; k < 17; k++) apply_stimulus();
    check_output("midreset_pre_txd", txd, 0);
    check_output("midreset_pre_busy", busy, 1);
    rst = 1'b1; v0 = 1'b1; d0 = 8'h96; acc0 = 1'b0;
    #3;
    check_output("midreset_txd", txd, 1);
    check_output("midreset_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rel_cyc = cyc;
    log_cyc.delete(); log_id.delete(); log_data.delete();
    wait_xfers(1, 5, "midreset_resume");
    check_output("midreset_first_edge", log_cyc[0], rel_cyc);
    check_output("midreset_data", log_data[0], 8'h96);
    drain(45);

    // req1 pulses valid for one cycle while busy: nothing may happen.
    do_reset();
    v0 = 1'b1; d0 = 8'h69;
    wait_xfers(1, 5, "withdraw_accept");
    for (int k = 0; k < 10; k++) apply_stimulus();
    v1 = 1'b1; d1 = 8'hEE;
    apply_stimulus();
    v1 = 1'b0;
    drain(40);
    check_output("withdraw_no_xfer", log_cyc.size(), 1);

    // Randomized traffic with occasional withdrawals and resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (acc0) begin acc0 = 1'b0; v0 = 1'b0; end
      if (acc1) begin acc1 = 1'b0; v1 = 1'b0; end
      if (!v0 && $urandom_range(0, 3) == 0) begin
        v0 = 1'b1; d0 = 8'($urandom);
      end else if (v0 && $urandom_range(0, 15) == 0) begin
        v0 = 1'b0;
      end
      if (!v1 && $urandom_range(0, 3) == 0) begin
        v1 = 1'b1; d1 = 8'($urandom);
      end else if (v1 && $urandom_range(0, 15) == 0) begin
        v1 = 1'b0;
      end
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
    drain(45);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 104, io_mainClk cycles per UART bit; legal range 2..65535.
REQ-002 io_mainClk  input  1  single clock; all state SHALL be clocked on the rising edge.
REQ-003 io_asyncReset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has a byte to send.
REQ-005 req0_data  input  8  requester 0 byte.
REQ-006 req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-007 req1_valid  input  1  requester 1 has a byte to send.
REQ-008 req1_data  input  8  requester 1 byte.
REQ-009 req1_ready  output  1  requester 1 byte accepted this cycle.
REQ-010 io_uart_txd  output  1  serial line, 8N1, LSB first, idle high.
REQ-011 busy  output  1  high while a frame is in progress (state != IDLE).
REQ-012 grant_id  output  1  requester whose byte is being sent; holds the last value when idle.

Function
REQ-013 FSM states: IDLE, START, DATA, STOP.
REQ-014 Transfer handshake: a byte SHALL transfer on a cycle where reqN_valid && reqN_ready.
REQ-015 reqN_ready SHALL be combinational: high only in IDLE, only for the granted requester; at most one ready high per cycle.
REQ-016 Arbitration in IDLE: one valid requester gets the grant; if both are valid, the one not granted last SHALL win (round robin).
REQ-017 The last-grant pointer SHALL reset to 1, so requester 0 wins the first contention.
REQ-018 On transfer: latch data into an 8-bit shift register, set grant_id, update the last-grant pointer, go to START next cycle.
REQ-019 START: txd=0 for CLKS_PER_BIT cycles, then DATA.
REQ-020 DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit, shift right after each bit, 8 bits, then STOP.
REQ-021 STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-022 Timing: txd SHALL fall on the first cycle after the transfer cycle; frame length is exactly 10*CLKS_PER_BIT cycles.
REQ-023 Back-to-back: a new transfer is possible on the first IDLE cycle, so frame starts are spaced at least 10*CLKS_PER_BIT+1 cycles.
REQ-024 Bit timer width: ceil(log2(CLKS_PER_BIT)) bits. The bit timer counts 0..CLKS_PER_BIT-1 and wraps to 0 on bit end. The bit index counts 0..7.
REQ-025 reqN_valid deasserted before ready: no transfer, no state change. Requester contract: valid and data held until ready.
REQ-026 io_uart_txd SHALL be driven from a register (glitch-free).
REQ-027 The requester not granted SHALL see ready=0 for the entire frame, whatever its valid.

Reset
REQ-028 While io_asyncReset=1: state=IDLE, txd=1, busy=0, grant_id=0, last-grant=1, timer=0, bit index=0, shift register=0.
REQ-029 Outputs SHALL take their reset values without waiting for a clock edge.
REQ-030 Reset mid-frame: txd SHALL return high immediately and the byte in flight SHALL be dropped, not resumed.
REQ-031 After reset deasserts, the first arbitration SHALL occur on the first rising edge.

Verification (CLKS_PER_BIT=4)
REQ-032 Single byte: req0_valid=1, data=0xA5 in IDLE -> req0_ready=1 for one cycle; txd reads 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each 4 cycles, 40 cycles total; busy high throughout.
REQ-033 Contention after reset: both valid, req0_data=0x11, req1_data=0x22 -> 0x11 is sent first (grant_id=0), then 0x22 (grant_id=1); the second start bit begins exactly 41 cycles after the first.
REQ-034 Fairness: both valid continuously for 4 frames -> grant_id sequence is 0,1,0,1; ready never high for both in one cycle.
REQ-035 Single requester streaming: req1 valid continuously, req0 idle -> every frame is granted to req1, spaced 41 cycles.
REQ-036 Reset mid-DATA: assert io_asyncReset at bit 3 -> txd=1 and busy=0 before the next clock edge; after release, a pending req0 is accepted on the first edge and its full frame is sent.
REQ-037 Valid withdrawn: req1_valid pulses for 1 cycle while busy -> no transfer, no ready, txd unaffected.
